shift_reg_fifo_flags: RTL and testbench

Parametrised successor to the shift-register FIFO. It adds an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags with a synchronous clear. It also adds a build-time choice between first-word-fall-through and registered read output. It sits between a producer and a consumer in the same clock domain and serves as a drop-in buffer wherever the basic FIFO is too bare.

---
 rtl/shift_reg_fifo_flags.sv | 156 +++++++++++++++
 tb/tb_shift_reg_fifo_flags.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/shift_reg_fifo_flags.sv
// shift_reg_fifo_flags
//
// Shift-register FIFO with an occupancy count and programmable almost-full
// and almost-empty flags. It also has sticky overflow/underflow error flags
// with a synchronous clear, and a build-time choice of read mode.
//
// Storage is mem_q[0..DEPTH-1] with mem_q[0] as the head (oldest word).
// A pop shifts every entry down by one. A push writes into the first free
// slot, taking the shift of the same cycle into account.
//
// Handshake: push is accepted when the FIFO is not full, or when a pop is
// accepted in the same cycle. pop is accepted when the FIFO is not empty. A
// request that is not accepted sets the matching sticky error flag, and it
// has no other effect.
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   push         write request
//   push_data    write data, captured when push is accepted
//   pop          read request
//   pop_data     read data. FWFT=1: the head, shown combinationally (0 when
//                empty). FWFT=0: registered, loaded on each accepted pop.
//   pop_valid    FWFT=1: !empty. FWFT=0: pulses one cycle after a pop.
//   empty        count == 0
//   full         count == DEPTH
//   almost_empty count <= AE_LVL
//   almost_full  count >= AF_LVL
//   count        occupancy, 0..DEPTH
//   overflow     sticky, set by a dropped push
//   underflow    sticky, set by an ignored pop
//   clr_err      synchronous clear of both sticky flags
module shift_reg_fifo_flags #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     wr_idx;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              acc_pop, acc_push;

    assign acc_pop  = pop & (count_q != '0);
    assign acc_push = push & ((count_q != CW'(DEPTH)) | acc_pop);

    // With a simultaneous pop, the write lands in the slot that the shift
    // has just freed.
    assign wr_idx = count_q - CW'(acc_pop);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (acc_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
        end
        if (acc_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == CW'(i)) begin
                    mem_d[i] = push_data;
                end
            end
        end
    end

    assign count_d = count_q + CW'(acc_push) - CW'(acc_pop);

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_comb begin
        overflow_d  = clr_err ? 1'b0 : overflow_q;
        underflow_d = clr_err ? 1'b0 : underflow_q;
        if (push & ~acc_push) begin
            overflow_d = 1'b1;
        end
        if (pop & ~acc_pop) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // The status flags are decoded only from the count register, so push
    // and pop never reach a flag combinationally.
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_empty = (count_q <= CW'(AE_LVL));
    assign almost_full  = (count_q >= CW'(AF_LVL));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    if (FWFT != 0) begin : g_fwft
        assign pop_data  = empty ? '0 : mem_q[0];
        assign pop_valid = ~empty;
    end else begin : g_reg
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= acc_pop;
                if (acc_pop) begin
                    rd_data_q <= mem_q[0];
                end
            end
        end

        assign pop_data  = rd_data_q;
        assign pop_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_shift_reg_fifo_flags.sv
// Bench for shift_reg_fifo_flags. It runs two instances from the same
// inputs: u_f uses the first-word-fall-through read mode and u_r uses the
// registered read mode.
module tb_shift_reg_fifo_flags;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        push = 1'b0;
    logic [31:0] push_data = '0;
    logic        pop = 1'b0;
    logic        clr_err = 1'b0;

    logic [31:0] f_data, r_data;
    logic        f_valid, r_valid;
    logic        f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic        r_empty, r_full, r_ae, r_af, r_ovf, r_unf;
    logic [3:0]  f_count, r_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_reg_fifo_flags #(.DEPTH(8), .DATA_W(32), .AF_LVL(6), .AE_LVL(2), .FWFT(1)) u_f (
        .clk(clk), .rstn(rstn), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(f_data), .pop_valid(f_valid), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
    );

    shift_reg_fifo_flags #(.DEPTH(8), .DATA_W(32), .AF_LVL(6), .AE_LVL(2), .FWFT(0)) u_r (
        .clk(clk), .rstn(rstn), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(r_data), .pop_valid(r_valid), .empty(r_empty), .full(r_full),
        .almost_empty(r_ae), .almost_full(r_af), .count(r_count),
        .overflow(r_ovf), .underflow(r_unf), .clr_err(clr_err)
    );

    typedef struct {
        logic        push;
        logic        pop;
        logic        clr;
        logic [31:0] data;
        int          cnt;
        logic        ovf;
        logic        unf;
        logic [31:0] fdata;
        logic        rvalid;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic p, input logic pp, input logic c, input logic [31:0] d,
                       input int cnt, input logic ovf, input logic unf,
                       input logic [31:0] fd, input logic rv, input logic [31:0] rd);
        vec_t v;
        v.push = p; v.pop = pp; v.clr = c; v.data = d; v.cnt = cnt;
        v.ovf = ovf; v.unf = unf; v.fdata = fd; v.rvalid = rv; v.rdata = rd;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] w(input int k);
        return 32'hFFFF_FFFF - 32'(100 * k);
    endfunction

    initial begin
        // Fill with eight words.
        for (int k = 0; k < 8; k++) add(1, 0, 0, w(k), k + 1, 0, 0, w(0), 0, 32'h0);
        // Push into a full FIFO: the word is dropped and overflow is set.
        add(1, 0, 0, 32'h1234_5678, 8, 1, 0, w(0), 0, 32'h0);
        add(0, 0, 1, 32'h0, 8, 0, 0, w(0), 0, 32'h0);
        // Full FIFO with push and pop together.
        add(1, 1, 0, 32'hDEAD_BEEF, 8, 0, 0, w(1), 1, w(0));
        // Drain: w1..w7, then DEADBEEF.
        for (int j = 1; j <= 8; j++)
            add(0, 1, 0, 32'h0, 8 - j, 0, 0,
                (j <= 6) ? w(j + 1) : ((j == 7) ? 32'hDEAD_BEEF : 32'h0),
                1, (j <= 7) ? w(j) : 32'hDEAD_BEEF);
        // Empty FIFO with push and pop together: the pop is ignored.
        add(1, 1, 0, 32'hA5A5_A5A5, 1, 0, 1, 32'hA5A5_A5A5, 0, 32'hDEAD_BEEF);
        add(0, 1, 1, 32'h0, 0, 0, 0, 32'h0, 1, 32'hA5A5_A5A5);
        // Clear and a new underflow in the same cycle: the event wins.
        add(0, 1, 1, 32'h0, 0, 0, 1, 32'h0, 0, 32'hA5A5_A5A5);
        add(0, 0, 1, 32'h0, 0, 0, 0, 32'h0, 0, 32'hA5A5_A5A5);
        // Registered read: three pushes, three pops, then an idle cycle.
        add(1, 0, 0, 32'h11, 1, 0, 0, 32'h11, 0, 32'hA5A5_A5A5);
        add(1, 0, 0, 32'h22, 2, 0, 0, 32'h11, 0, 32'hA5A5_A5A5);
        add(1, 0, 0, 32'h33, 3, 0, 0, 32'h11, 0, 32'hA5A5_A5A5);
        add(0, 1, 0, 32'h0, 2, 0, 0, 32'h22, 1, 32'h11);
        add(0, 1, 0, 32'h0, 1, 0, 0, 32'h33, 1, 32'h22);
        add(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 1, 32'h33);
        add(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h33);
        // Push and pop together at count 1.
        add(1, 0, 0, 32'h44, 1, 0, 0, 32'h44, 0, 32'h33);
        add(1, 1, 0, 32'h55, 1, 0, 0, 32'h55, 1, 32'h44);
        add(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 1, 32'h55);
        // An ignored pop, so that underflow is set before the reset test.
        add(0, 1, 0, 32'h0, 0, 0, 1, 32'h0, 0, 32'h55);

        // Reset state, sampled while rstn is held low.
        #20;
        chk("rst_count", 32'(f_count), 32'd0);
        chk("rst_empty", 32'(f_empty), 32'd1);
        chk("rst_ae", 32'(f_ae), 32'd1);
        chk("rst_full", 32'(f_full), 32'd0);
        chk("rst_af", 32'(f_af), 32'd0);
        chk("rst_ovf", 32'(f_ovf | r_ovf), 32'd0);
        chk("rst_unf", 32'(f_unf | r_unf), 32'd0);
        chk("rst_fvalid", 32'(f_valid), 32'd0);
        chk("rst_rvalid", 32'(r_valid), 32'd0);
        chk("rst_fdata", f_data, 32'h0);
        chk("rst_rdata", r_data, 32'h0);
        #10 rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            push = vecs[i].push; pop = vecs[i].pop; clr_err = vecs[i].clr;
            push_data = vecs[i].data;
            @(posedge clk); #1;
            chk($sformatf("v%0d_count", i), 32'(f_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_rcount", i), 32'(r_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_empty", i), 32'(f_empty), 32'(vecs[i].cnt == 0));
            chk($sformatf("v%0d_ae", i), 32'(f_ae), 32'(vecs[i].cnt <= 2));
            chk($sformatf("v%0d_af", i), 32'(f_af), 32'(vecs[i].cnt >= 6));
            chk($sformatf("v%0d_full", i), 32'(f_full), 32'(vecs[i].cnt == 8));
            chk($sformatf("v%0d_rflags", i), {28'h0, r_empty, r_ae, r_af, r_full},
                {28'h0, vecs[i].cnt == 0, vecs[i].cnt <= 2, vecs[i].cnt >= 6, vecs[i].cnt == 8});
            chk($sformatf("v%0d_ovf", i), 32'(f_ovf), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_unf", i), 32'(f_unf), 32'(vecs[i].unf));
            chk($sformatf("v%0d_rerr", i), {30'h0, r_ovf, r_unf}, {30'h0, vecs[i].ovf, vecs[i].unf});
            chk($sformatf("v%0d_fdata", i), f_data, vecs[i].fdata);
            chk($sformatf("v%0d_fvalid", i), 32'(f_valid), 32'(vecs[i].cnt != 0));
            chk($sformatf("v%0d_rvalid", i), 32'(r_valid), 32'(vecs[i].rvalid));
            chk($sformatf("v%0d_rdata", i), r_data, vecs[i].rdata);
        end

        // Reset in the middle of operation, with count=5 and underflow set.
        pop = 1'b0; clr_err = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push = 1'b1; push_data = 32'h100 + 32'(k);
            @(posedge clk); #1;
        end
        push = 1'b0;
        chk("mid_pre_count", 32'(f_count), 32'd5);
        chk("mid_pre_unf", 32'(f_unf), 32'd1);
        #3 rstn = 1'b0;
        #1;
        chk("mid_count", 32'(f_count), 32'd0);
        chk("mid_rcount", 32'(r_count), 32'd0);
        chk("mid_empty", 32'(f_empty), 32'd1);
        chk("mid_fdata", f_data, 32'h0);
        chk("mid_rdata", r_data, 32'h0);
        chk("mid_err", {28'h0, f_ovf, f_unf, r_ovf, r_unf}, 32'h0);
        #2 rstn = 1'b1;
        push = 1'b1; push_data = 32'hCAFE_0001;
        @(posedge clk); #1;
        push = 1'b0;
        chk("post_rst_count", 32'(f_count), 32'd1);
        chk("post_rst_fdata", f_data, 32'hCAFE_0001);
        chk("post_rst_fvalid", 32'(f_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
